collective_route_gen: RTL and testbench

//  Parametrised successor of the per-node collective destination generator. It sits between the

---
 rtl/collective_route_gen.sv | 138 +++++++++++++
 tb/tb_collective_route_gen.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/collective_route_gen.sv
// Collective destination generator: rewrites injected collective flits from a runtime-writable
// communicator table, sending uptree flits to the parent and fanning broadcasts out to each child.
module collective_route_gen #(
  parameter int FlitWidth     = 73,
  parameter int CoordWidth    = 9,
  parameter int ChildrenWidth = 3,
  parameter int MaxChildren   = 4,
  parameter int CommTableSize = 4,
  parameter int CtxAddrWidth  = 2,
  parameter int EntryWidth    = 1 + 1 + ChildrenWidth + CoordWidth * (MaxChildren + 1),
  parameter logic [CoordWidth-1:0] LocalCoord = '0,
  parameter logic [3:0] BcastOp = 4'b1111
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [FlitWidth-1:0]               in_flit,
  input  logic                               in_valid,
  output logic                               in_ready,
  output logic [FlitWidth+ChildrenWidth-1:0] out_flit,
  output logic                               out_valid,
  input  logic                               out_ready,
  input  logic                               cfg_we,
  input  logic [CtxAddrWidth-1:0]            cfg_addr,
  input  logic [EntryWidth-1:0]              cfg_data,
  output logic                               drop_err
);

  localparam int VldBit  = FlitWidth - 1;
  localparam int DstLsb  = VldBit - CoordWidth;
  localparam int CtxLsb  = VldBit - 2 * CoordWidth - 8;
  localparam int OpLsb   = 32;
  localparam int KidsW   = CoordWidth * MaxChildren;
  localparam int EnBit   = EntryWidth - 1;
  localparam int RootBit = EntryWidth - 2;
  localparam int NLsb    = RootBit - ChildrenWidth;
  localparam int ParLsb  = NLsb - CoordWidth;

  typedef enum logic {IDLE, BCAST} state_t;

  state_t                   state;
  logic [EntryWidth-1:0]    table_q [CommTableSize];
  logic [FlitWidth-1:0]     flit_p1;
  logic [KidsW-1:0]         kids_p1;
  logic [ChildrenWidth-1:0] nkids_p1;
  logic [ChildrenWidth-1:0] idx;

  logic [7:0]               ctx;
  logic [3:0]               op;
  logic [EntryWidth-1:0]    ent;
  logic                     ctx_ok;
  logic                     accept;
  logic [ChildrenWidth-1:0] ent_n;
  logic [CoordWidth-1:0]    ent_par;
  logic [KidsW-1:0]         ent_kids;
  logic [CoordWidth-1:0]    up_dst;

  function automatic logic [FlitWidth-1:0] with_dst(input logic [FlitWidth-1:0] f,
                                                    input logic [CoordWidth-1:0] d);
    with_dst = f;
    with_dst[DstLsb +: CoordWidth] = d;
  endfunction

  function automatic logic [CoordWidth-1:0] child_at(input logic [KidsW-1:0] k,
                                                     input logic [ChildrenWidth-1:0] i);
    child_at = k[CoordWidth * int'(i) +: CoordWidth];
  endfunction

  function automatic logic [ChildrenWidth-1:0] clamp_n(input logic [ChildrenWidth-1:0] n);
    clamp_n = (32'(n) > MaxChildren) ? ChildrenWidth'(MaxChildren) : n;
  endfunction

  // Table lookup happens on the registered table, so a same-cycle cfg write is seen only by later flits.
  assign ctx      = in_flit[CtxLsb +: 8];
  assign op       = in_flit[OpLsb +: 4];
  assign ent      = table_q[ctx[CtxAddrWidth-1:0]];
  assign ctx_ok   = 32'(ctx) < CommTableSize;
  assign ent_n    = ent[NLsb +: ChildrenWidth];
  assign ent_par  = ent[ParLsb +: CoordWidth];
  assign ent_kids = ent[KidsW-1:0];
  assign up_dst   = ent[RootBit] ? LocalCoord : ent_par;
  assign in_ready = (state == IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  // Stage p1: snapshot of the accepted flit and its entry; out_flit always holds copy idx.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      out_valid <= 1'b0;
      out_flit  <= '0;
      drop_err  <= 1'b0;
      for (int i = 0; i < CommTableSize; i++) table_q[i] <= '0;
    end else begin
      drop_err <= 1'b0;
      if (cfg_we) table_q[cfg_addr] <= cfg_data;
      unique case (state)
        IDLE: begin
          if (accept) begin
            out_valid <= 1'b0;
            if (!in_flit[VldBit]) begin
              out_valid <= 1'b0;
            end else if (!ctx_ok || !ent[EnBit]) begin
              drop_err <= 1'b1;
            end else if (op != BcastOp) begin
              out_valid <= 1'b1;
              out_flit  <= {ent_n, with_dst(in_flit, up_dst)};
            end else if (clamp_n(ent_n) != '0) begin
              state     <= BCAST;
              idx       <= '0;
              flit_p1   <= in_flit;
              kids_p1   <= ent_kids;
              nkids_p1  <= clamp_n(ent_n);
              out_valid <= 1'b1;
              out_flit  <= {{ChildrenWidth{1'b0}}, with_dst(in_flit, child_at(ent_kids, '0))};
            end
          end else if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        BCAST: begin
          if (out_ready) begin
            if (idx == nkids_p1 - 1'b1) begin
              state     <= IDLE;
              idx       <= '0;
              out_valid <= 1'b0;
            end else begin
              idx      <= idx + 1'b1;
              out_flit <= {{ChildrenWidth{1'b0}},
                           with_dst(flit_p1, child_at(kids_p1, idx + 1'b1))};
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_collective_route_gen.sv
// Bench for collective_route_gen: directed vector table, hand-written broadcast/reset sequences,
// then randomized traffic checked against a queue-based reference model.
module tb_collective_route_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic [72:0] in_flit;
  logic        in_valid;
  logic        in_ready;
  logic [75:0] out_flit;
  logic        out_valid;
  logic        out_ready;
  logic        cfg_we;
  logic [1:0]  cfg_addr;
  logic [49:0] cfg_data;
  logic        drop_err;

  int errors = 0;
  int checks = 0;

  collective_route_gen dut (
    .clk(clk), .rst(rst), .in_flit(in_flit), .in_valid(in_valid), .in_ready(in_ready),
    .out_flit(out_flit), .out_valid(out_valid), .out_ready(out_ready),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .drop_err(drop_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] ctx; logic vld; logic [3:0] op;
    logic ov; logic [8:0] dst; logic [2:0] ch; logic drop;
  } vec_t;
  vec_t vec [9];

  typedef struct { logic [75:0] flit; bit bc; } exp_t;
  exp_t        q [$];
  logic [49:0] mtab [4];
  logic        drop_exp;

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic logic [72:0] mk(input logic v, input logic [7:0] c, input logic [3:0] o,
                                     input logic [31:0] pay);
    mk = {v, 9'h1FF, 9'h0A3, c, 8'h5A, 2'b10, o, pay};
  endfunction

  function automatic logic [72:0] setdst(input logic [72:0] f, input logic [8:0] d);
    setdst = f;
    setdst[71:63] = d;
  endfunction

  function automatic logic [49:0] ent(input logic en, input logic root, input logic [2:0] n,
                                      input logic [8:0] par, input logic [8:0] c3,
                                      input logic [8:0] c2, input logic [8:0] c1,
                                      input logic [8:0] c0);
    ent = {en, root, n, par, c3, c2, c1, c0};
  endfunction

  task automatic cfg(input logic [1:0] a, input logic [49:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic send(input logic [72:0] f);
    in_flit = f; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // Broadcast with out_ready held high: n consecutive copies, in_ready low throughout.
  task automatic bcast_chk(input logic [72:0] f, input logic [3:0][8:0] d, input int n);
    out_ready = 1'b1;
    send(f);
    for (int k = 0; k < n; k++) begin
      chk("bc_valid", 128'(out_valid), 128'(1));
      chk("bc_flit", 128'(out_flit), 128'({3'b000, setdst(f, d[k])}));
      chk("bc_in_ready", 128'(in_ready), 128'(0));
      tick();
    end
    chk("bc_end_valid", 128'(out_valid), 128'(0));
    chk("bc_end_ready", 128'(in_ready), 128'(1));
  endtask

  task automatic model_step();
    logic        rdy;
    logic [7:0]  c;
    logic [49:0] e;
    int          n;
    rdy = (q.size() == 0) || (q.size() == 1 && !q[0].bc && out_ready);
    chk("r_valid", 128'(out_valid), 128'(q.size() != 0));
    if (q.size() != 0) chk("r_flit", 128'(out_flit), 128'(q[0].flit));
    chk("r_in_ready", 128'(in_ready), 128'(rdy));
    chk("r_drop", 128'(drop_err), 128'(drop_exp));
    if (rst) begin
      q.delete();
      drop_exp = 1'b0;
      foreach (mtab[i]) mtab[i] = '0;
      return;
    end
    if (q.size() != 0 && out_ready) void'(q.pop_front());
    drop_exp = 1'b0;
    if (in_valid && rdy && in_flit[72]) begin
      c = in_flit[53:46];
      e = (c < 8'd4) ? mtab[c[1:0]] : '0;
      if (!e[49]) begin
        drop_exp = 1'b1;
      end else if (in_flit[35:32] != 4'hF) begin
        q.push_back('{{e[47:45], setdst(in_flit, e[48] ? 9'h000 : e[44:36])}, 1'b0});
      end else begin
        n = int'(e[47:45]);
        if (n > 4) n = 4;
        for (int k = 0; k < n; k++)
          q.push_back('{{3'b000, setdst(in_flit, 9'((e >> (9 * k)) & 50'h1FF))}, 1'b1});
      end
    end
    if (cfg_we) mtab[cfg_addr] = cfg_data;
  endtask

  initial begin
    logic [72:0]      f;
    logic [49:0]      e0;
    logic [49:0]      e0b;
    logic [3:0]       pat;
    logic [3:0][8:0]  d;
    int               k;

    rst = 1'b1; in_flit = '0; in_valid = 1'b0; out_ready = 1'b1;
    cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;

    vec[0] = '{8'd0,   1'b1, 4'h0, 1'b1, 9'h049, 3'd3, 1'b0};
    vec[1] = '{8'd0,   1'b1, 4'h5, 1'b1, 9'h049, 3'd3, 1'b0};
    vec[2] = '{8'd5,   1'b1, 4'h0, 1'b0, 9'h000, 3'd0, 1'b1};
    vec[3] = '{8'd1,   1'b1, 4'h0, 1'b0, 9'h000, 3'd0, 1'b1};
    vec[4] = '{8'd2,   1'b1, 4'h0, 1'b1, 9'h000, 3'd2, 1'b0};
    vec[5] = '{8'd3,   1'b1, 4'hF, 1'b0, 9'h000, 3'd0, 1'b0};
    vec[6] = '{8'd0,   1'b0, 4'h0, 1'b0, 9'h000, 3'd0, 1'b0};
    vec[7] = '{8'd3,   1'b1, 4'h7, 1'b1, 9'h055, 3'd0, 1'b0};
    vec[8] = '{8'd200, 1'b1, 4'hF, 1'b0, 9'h000, 3'd0, 1'b1};

    e0  = ent(1'b1, 1'b0, 3'd3, 9'h049, 9'h000, 9'h008, 9'h001, 9'h040);
    e0b = ent(1'b1, 1'b0, 3'd3, 9'h111, 9'h000, 9'h1E2, 9'h1E1, 9'h1E0);

    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_valid", 128'(out_valid), 128'(0));
    chk("rst_flit", 128'(out_flit), 128'(0));
    chk("rst_drop", 128'(drop_err), 128'(0));
    chk("rst_in_ready", 128'(in_ready), 128'(1));

    cfg(2'd0, e0);
    cfg(2'd2, ent(1'b1, 1'b1, 3'd2, 9'h1AB, 9'h000, 9'h000, 9'h0F0, 9'h0A0));
    cfg(2'd3, ent(1'b1, 1'b0, 3'd0, 9'h055, 9'h000, 9'h000, 9'h000, 9'h000));

    for (int i = 0; i < 9; i++) begin
      f = mk(vec[i].vld, vec[i].ctx, vec[i].op, 32'hC0DE_0000 + 32'(i));
      send(f);
      chk("vec_valid", 128'(out_valid), 128'(vec[i].ov));
      if (vec[i].ov) chk("vec_flit", 128'(out_flit), 128'({vec[i].ch, setdst(f, vec[i].dst)}));
      chk("vec_drop", 128'(drop_err), 128'(vec[i].drop));
      tick();
      chk("vec_idle", 128'({out_valid, drop_err}), 128'(0));
    end

    // Back-to-back uptree flits at one per cycle.
    out_ready = 1'b1;
    in_flit = mk(1'b1, 8'd0, 4'h0, 32'h0000_AAAA); in_valid = 1'b1;
    f = in_flit;
    tick();
    chk("b2b_first", 128'(out_flit), 128'({3'd3, setdst(f, 9'h049)}));
    chk("b2b_in_ready", 128'(in_ready), 128'(1));
    in_flit = mk(1'b1, 8'd2, 4'h1, 32'h0000_BBBB);
    f = in_flit;
    tick();
    in_valid = 1'b0;
    chk("b2b_second", 128'(out_flit), 128'({3'd2, setdst(f, 9'h000)}));
    chk("b2b_second_valid", 128'(out_valid), 128'(1));
    tick();

    // Same-cycle cfg write to the looked-up entry: old entry applies, new one afterwards.
    f = mk(1'b1, 8'd0, 4'h2, 32'h1234_5678);
    cfg_we = 1'b1; cfg_addr = 2'd0; cfg_data = e0b; in_flit = f; in_valid = 1'b1;
    tick();
    cfg_we = 1'b0; in_valid = 1'b0;
    chk("rbw_old", 128'(out_flit), 128'({3'd3, setdst(f, 9'h049)}));
    tick();
    send(f);
    chk("rbw_new", 128'(out_flit), 128'({3'd3, setdst(f, 9'h111)}));
    tick();
    cfg(2'd0, e0);

    d = {9'h000, 9'h008, 9'h001, 9'h040};
    bcast_chk(mk(1'b1, 8'd0, 4'hF, 32'hB0B0_0001), d, 3);

    // Clamp: n_children=6 issues only MaxChildren copies.
    cfg(2'd1, ent(1'b1, 1'b0, 3'd6, 9'h000, 9'h1C3, 9'h1C2, 9'h1C1, 9'h1C0));
    d = {9'h1C3, 9'h1C2, 9'h1C1, 9'h1C0};
    bcast_chk(mk(1'b1, 8'd1, 4'hF, 32'hB0B0_0002), d, 4);

    // Stalled broadcast: each copy held while out_ready is low.
    d = {9'h000, 9'h008, 9'h001, 9'h040};
    pat = 4'b1001;
    out_ready = 1'b0;
    f = mk(1'b1, 8'd0, 4'hF, 32'hB0B0_0003);
    send(f);
    k = 0;
    for (int i = 0; i < 24 && k < 3; i++) begin
      chk("stall_valid", 128'(out_valid), 128'(1));
      chk("stall_flit", 128'(out_flit), 128'({3'b000, setdst(f, d[k])}));
      out_ready = pat[i % 4];
      if (out_ready) k++;
      tick();
    end
    chk("stall_copies", 128'(k), 128'(3));
    chk("stall_no_dup", 128'(out_valid), 128'(0));
    out_ready = 1'b1;

    // Reset mid-broadcast aborts the fan-out and clears the table.
    f = mk(1'b1, 8'd0, 4'hF, 32'hB0B0_0004);
    send(f);
    chk("abort_copy0", 128'(out_flit), 128'({3'b000, setdst(f, 9'h040)}));
    tick();
    chk("abort_copy1", 128'(out_flit), 128'({3'b000, setdst(f, 9'h001)}));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_valid", 128'(out_valid), 128'(0));
    chk("abort_in_ready", 128'(in_ready), 128'(1));
    send(mk(1'b1, 8'd0, 4'h0, 32'hDEAD_0000));
    chk("abort_cleared_valid", 128'(out_valid), 128'(0));
    chk("abort_cleared_drop", 128'(drop_err), 128'(1));
    tick();

    // Randomized traffic against the reference model.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    q.delete();
    foreach (mtab[i]) mtab[i] = '0;
    drop_exp = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      rst       = ($urandom_range(0, 299) == 0);
      in_valid  = ($urandom_range(0, 9) < 7);
      in_flit   = {($urandom_range(0, 9) != 0), 9'($urandom), 9'($urandom),
                   ($urandom_range(0, 19) == 0) ? 8'($urandom) : 8'($urandom_range(0, 5)),
                   8'($urandom), 2'($urandom),
                   ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom), 32'($urandom)};
      out_ready = ($urandom_range(0, 9) < 7);
      cfg_we    = ($urandom_range(0, 9) == 0);
      cfg_addr  = 2'($urandom);
      cfg_data  = {($urandom_range(0, 4) != 0), ($urandom_range(0, 3) == 0), 3'($urandom),
                   9'($urandom), 36'({$urandom, $urandom})};
      #1;
      model_step();
      tick();
    end
    in_valid = 1'b0; cfg_we = 1'b0; rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
